conv_out_collector: RTL
=======================

# conv_out_collector

Sits at the output end of the streaming convolution datapath, where image pixels are shifted through fixed-depth line buffers every clock. It tracks the raster position of every pixel entering the pipeline. It marks which pipeline results correspond to fully-populated KERNEL_WIDTH×KERNEL_WIDTH windows, discards wrap-around and fill results, and presents only valid convolution outputs with their output row/column coordinates.

## Interface
- IMAGE_WIDTH, 28: input image is IMAGE_WIDTH×IMAGE_WIDTH, raster order.
- KERNEL_WIDTH, 5: square kernel size; OUT_W = IMAGE_WIDTH-KERNEL_WIDTH+1 (24).
- PIPE_LAT, 3: cycles from a pixel entering the pipeline to its window's result on conv_data; legal range 0..63.
- DATA_W, 40: signed result width.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- pix_valid  in  1  pixel entering the convolution pipeline this cycle.
- frame_start  in  1  qualifies the pixel with pix_valid as pixel (0,0) of a frame.
- conv_data  in  DATA_W  signed pipeline result, free-running every cycle.
- out_valid  out  1  out_data/out_row/out_col hold a valid window result.
- out_data  out  DATA_W  signed result, passed through unmodified.
- out_row, out_col  out  $clog2(OUT_W) each  output coordinate, 0..OUT_W-1.
- out_last  out  1  with out_valid on the final output (OUT_W-1, OUT_W-1).
- busy  out  1  frame in progress: from accepted frame_start until the cycle after the last out_valid.
- err  out  1  sticky: frame underrun detected.

## Operation
- Reset values: out_valid, out_last, busy, err = 0; out_data, out_row, out_col = 0.
- Input tracker states: IDLE, RUN. IDLE→RUN on frame_start & pix_valid; pixel index p = 0, position (r,c) = (0,0). In RUN each pix_valid cycle advances c, wrapping at IMAGE_WIDTH into r+1. RUN→IDLE after pixel p = IMAGE_WIDTH²-1.
- A pixel at (r,c) completes a valid window iff r ≥ KERNEL_WIDTH-1 and c ≥ KERNEL_WIDTH-1. Output coordinate = (r-KERNEL_WIDTH+1, c-KERNEL_WIDTH+1).
- The tag (valid, row, col, last) for each pixel travels PIPE_LAT cycles. It is then paired with conv_data of that cycle and registered onto the outputs. Non-valid tags produce out_valid = 0; out_data then holds its last value.
- pix_valid without frame_start in IDLE: ignored.
- pix_valid low while in RUN: underrun. err set, tracker → IDLE, all in-flight tags cleared, busy drops next cycle.
- frame_start & pix_valid while in RUN: abort. In-flight tags of the old frame are cleared and a new frame starts at p = 0 in that same cycle. err is not set.
- frame_start & pix_valid in IDLE while old tags are still draining: accepted. The old frame's remaining outputs are still emitted in order, and busy stays high.
- err clears only on reset or on the next accepted frame_start.
- Outputs per frame: exactly OUT_W² out_valid pulses. Each output row is OUT_W consecutive pulses followed by a KERNEL_WIDTH-1 cycle gap.

## Timing
- A pixel accepted at cycle t0+p produces its output at cycle t0+p+PIPE_LAT+1, with out_data = conv_data sampled at t0+p+PIPE_LAT.
- Throughput: one pixel per cycle in, at most one result per cycle out; no backpressure.
- Reset asserted mid-frame: all outputs 0 asynchronously; no output until the next frame_start after reset release.

## Test plan
- Reset, then a full frame (W=28, K=5, PIPE_LAT=3, conv_data = cycle count) -> first out_valid 120 cycles after frame_start with (0,0) and out_data = 119. Last out_valid at 787 with (23,23) and out_last = 1. Total 576 pulses, 4-cycle gap after each row, busy low at 788.
- pix_valid dropped at p = 300 -> err = 1, no further out_valid, busy = 0. A following clean frame clears err and yields 576 outputs.
- frame_start reasserted at p = 500 -> old tags discarded; next out_valid 120 cycles later with (0,0); 576 outputs follow.
- Back-to-back frames (second frame_start the cycle after p = 783) -> 1152 outputs, busy continuously high, out_last twice.
- PIPE_LAT = 0 and PIPE_LAT = 63 -> first output at 117 and 180 cycles respectively.
- Async reset at p = 600 -> all outputs 0 immediately; no outputs after release until a new frame_start.

Source files
------------

// File: rtl/conv_out_collector_if.sv
// conv_out_collector_if: pixel-entry inputs and window-result outputs of the
// convolution output collector. master feeds pixels, slave is the collector.
//   pix_valid, frame_start : pixel entering the pipeline / first pixel of frame
//   conv_data              : free-running signed pipeline result
//   out_valid/out_data     : valid window result and its value
//   out_row/out_col        : output coordinate, out_last on the final one
//   busy, err              : frame in progress, sticky underrun flag
interface conv_out_collector_if #(
    parameter int DATA_W = 40,
    parameter int CW     = 5
);
    logic                     pix_valid;
    logic                     frame_start;
    logic signed [DATA_W-1:0] conv_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [CW-1:0]            out_row;
    logic [CW-1:0]            out_col;
    logic                     out_last;
    logic                     busy;
    logic                     err;

    modport master (
        output pix_valid,
        output frame_start,
        output conv_data,
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        input  busy,
        input  err
    );

    modport slave (
        input  pix_valid,
        input  frame_start,
        input  conv_data,
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        output busy,
        output err
    );
endinterface

// File: rtl/conv_out_collector.sv
// conv_out_collector: tracks raster position of pixels entering the conv
// pipeline and emits only results of fully-populated KxK windows.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : conv_out_collector_if.slave (pixel in, results out)
module conv_out_collector #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int KERNEL_WIDTH = 5,
    parameter int PIPE_LAT     = 3,
    parameter int DATA_W       = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_out_collector_if.slave  bus
);
    localparam int OUT_W = IMAGE_WIDTH - KERNEL_WIDTH + 1;
    localparam int AW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(IMAGE_WIDTH - 1);
    localparam logic [AW-1:0] KM1      = AW'(KERNEL_WIDTH - 1);

    if (PIPE_LAT < 0 || PIPE_LAT > 63) begin : g_bad_lat
        $error("conv_out_collector: PIPE_LAT out of range 0..63");
    end
    if (KERNEL_WIDTH < 1 || KERNEL_WIDTH > IMAGE_WIDTH) begin : g_bad_k
        $error("conv_out_collector: KERNEL_WIDTH must be 1..IMAGE_WIDTH");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // Window tag that rides alongside a pixel through the pipeline.
    typedef struct packed {
        logic          vld;
        logic          last;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } tag_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] r_q;
    logic [AW-1:0] c_q;
    logic [AW-1:0] r_d;
    logic [AW-1:0] c_d;

    logic          in_run;
    logic          start;
    logic          accept;
    logic          underrun;
    logic          abort;
    logic          flush;
    logic          at_last;
    logic [AW-1:0] cur_r;
    logic [AW-1:0] cur_c;

    tag_t          cur_tag;
    tag_t          lat_tag;
    logic          pipe_busy;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic [CW-1:0]            out_row_q;
    logic [CW-1:0]            out_col_q;
    logic                     out_last_q;
    logic                     err_q;

    // Event decode for the current cycle.
    always_comb begin
        in_run   = (state_q == S_RUN);
        start    = bus.pix_valid & bus.frame_start;
        accept   = start | (in_run & bus.pix_valid);
        underrun = in_run & ~bus.pix_valid;
        abort    = in_run & start;
        flush    = underrun | abort;
        // A frame_start always restarts the raster at (0,0).
        cur_r    = start ? '0 : r_q;
        cur_c    = start ? '0 : c_q;
        at_last  = (cur_r == LAST_IDX) && (cur_c == LAST_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        unique case (1'b1)
            underrun: begin
                state_d = S_IDLE;
            end
            accept & at_last: begin
                state_d = S_IDLE;
                r_d     = '0;
                c_d     = '0;
            end
            accept & ~at_last: begin
                state_d = S_RUN;
                if (cur_c == LAST_IDX) begin
                    c_d = '0;
                    r_d = cur_r + 1'b1;
                end else begin
                    c_d = cur_c + 1'b1;
                    r_d = cur_r;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Tag for the pixel entering this cycle.
    always_comb begin
        cur_tag     = '0;
        cur_tag.vld = accept && (cur_r >= KM1) && (cur_c >= KM1);
        cur_tag.last = cur_tag.vld && at_last;
        cur_tag.row = CW'(cur_r - KM1);
        cur_tag.col = CW'(cur_c - KM1);
    end

    // Tag delay line matching the conv pipeline latency.
    if (PIPE_LAT == 0) begin : g_nolat
        assign lat_tag   = cur_tag;
        assign pipe_busy = 1'b0;
    end else begin : g_lat
        tag_t stage_q [PIPE_LAT];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                // Stage 0 takes the new pixel even on abort; older
                // stages are wiped so the old frame never surfaces.
                stage_q[0] <= cur_tag;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    stage_q[i] <= flush ? '0 : stage_q[i-1];
                end
            end
        end

        assign lat_tag = flush ? '0 : stage_q[PIPE_LAT-1];

        always_comb begin
            pipe_busy = 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_busy = pipe_busy | stage_q[i].vld;
            end
        end
    end

    // Output register: pair the matured tag with this cycle's result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= lat_tag.vld;
            out_last_q  <= lat_tag.last;
            if (lat_tag.vld) begin
                out_data_q <= bus.conv_data;
                out_row_q  <= lat_tag.row;
                out_col_q  <= lat_tag.col;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (underrun) begin
            err_q <= 1'b1;
        end else if (start) begin
            err_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
    // Busy while pixels stream, tags are in flight, or a result is shown.
    assign bus.busy      = in_run | pipe_busy | out_valid_q;
endmodule
